// File: rtl/credit_sender_if.sv
// rtl/credit_sender_if.sv - payload, receiver write and credit signals of credit_sender
interface credit_sender_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] input_port_data;
    logic                  input_port_valid;
    logic                  input_port_ready;
    logic [DATA_WIDTH-1:0] output_data;
    logic                  output_valid;
    logic                  credit_return;
    logic [3:0]            credit_count;
    logic                  credit_error;

    modport master (
        input  input_port_data,
        input  input_port_valid,
        output input_port_ready,
        output output_data,
        output output_valid,
        input  credit_return,
        output credit_count,
        output credit_error
    );

    modport slave (
        output input_port_data,
        output input_port_valid,
        input  input_port_ready,
        input  output_data,
        input  output_valid,
        output credit_return,
        input  credit_count,
        input  credit_error
    );
endinterface

// File: rtl/credit_sender.sv
// rtl/credit_sender.sv - credit-based sender feeding a remote receiver FIFO of DEPTH entries
// Optional macro CREDIT_SENDER_BYPASS_EN lets a returning credit enable a send at zero credits.
module credit_sender #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 10
) (
    input  logic               clock_port,
    input  logic               reset_port,
    input  logic               clear,
    credit_sender_if.master    bus
);

    localparam logic [3:0] DEPTH_C = 4'(DEPTH);

    logic [3:0]            credit_count_q, credit_count_d;
    logic                  credit_error_q, credit_error_d;
    logic                  output_valid_q, output_valid_d;
    logic [DATA_WIDTH-1:0] output_data_q,  output_data_d;
    logic                  ready;
    logic                  send;

`ifdef CREDIT_SENDER_BYPASS_EN
    assign ready = ((credit_count_q != 4'd0) | bus.credit_return) & ~clear;
`else
    assign ready = (credit_count_q != 4'd0) & ~clear;
`endif

    assign send = bus.input_port_valid & ready;

    always_comb begin
        credit_count_d = credit_count_q;
        credit_error_d = credit_error_q;
        output_valid_d = send;
        output_data_d  = send ? bus.input_port_data : output_data_q;

        case ({send, bus.credit_return})
            2'b10: credit_count_d = credit_count_q - 4'd1;
            2'b01: begin
                // A return with the receiver already empty is a protocol error; hold at DEPTH.
                if (credit_count_q == DEPTH_C) begin
                    credit_error_d = 1'b1;
                end else begin
                    credit_count_d = credit_count_q + 4'd1;
                end
            end
            default: credit_count_d = credit_count_q;
        endcase

        // Clear discards any in-flight transfer and any credit returned this cycle.
        if (clear) begin
            credit_count_d = DEPTH_C;
            credit_error_d = 1'b0;
            output_valid_d = 1'b0;
            output_data_d  = '0;
        end
    end

    always_ff @(posedge clock_port) begin
        if (reset_port) begin
            credit_count_q <= DEPTH_C;
            credit_error_q <= 1'b0;
            output_valid_q <= 1'b0;
            output_data_q  <= '0;
        end else begin
            credit_count_q <= credit_count_d;
            credit_error_q <= credit_error_d;
            output_valid_q <= output_valid_d;
            output_data_q  <= output_data_d;
        end
    end

    assign bus.input_port_ready = ready;
    assign bus.output_data      = output_data_q;
    assign bus.output_valid     = output_valid_q;
    assign bus.credit_count     = credit_count_q;
    assign bus.credit_error     = credit_error_q;

endmodule

// File: tb/tb_credit_sender.sv
// tb/tb_credit_sender.sv - directed vector table plus ordered random-gap stream for credit_sender
module tb_credit_sender;

`ifdef CREDIT_SENDER_BYPASS_EN
    localparam bit BP = 1'b1;
`else
    localparam bit BP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    logic clr;

    credit_sender_if #(.DATA_WIDTH(8)) bus ();

    credit_sender #(.DATA_WIDTH(8), .DEPTH(10)) dut (
        .clock_port (clk),
        .reset_port (rst),
        .clear      (clr),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       valid;
        logic [7:0] data;
        logic       ret;
        logic       clr;
        logic       e_ready;
        logic       e_ov;
        logic [7:0] e_od;
        logic [3:0] e_cnt;
        logic       e_err;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic void add(logic v, logic [7:0] d, logic r, logic c,
                                logic er, logic eov, logic [7:0] eod, logic [3:0] ecnt, logic eerr);
        vec_t t;
        t.valid = v; t.data = d; t.ret = r; t.clr = c;
        t.e_ready = er; t.e_ov = eov; t.e_od = eod; t.e_cnt = ecnt; t.e_err = eerr;
        vecs.push_back(t);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(logic v, logic [7:0] d, logic r, logic c);
        bus.input_port_valid = v;
        bus.input_port_data  = d;
        bus.credit_return    = r;
        clr                  = c;
    endtask

    logic [7:0] exp_q[$];
    int         occ, model_cnt, sent, got;
    logic [7:0] next_data;
    logic       v_r, r_r, snd;

    initial begin
        rst = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("reset_ready", 32'(bus.input_port_ready), 32'd1);
        chk("reset_ov",    32'(bus.output_valid),     32'd0);
        chk("reset_od",    32'(bus.output_data),      32'd0);
        chk("reset_cnt",   32'(bus.credit_count),     32'd10);
        chk("reset_err",   32'(bus.credit_error),     32'd0);

        // drain all ten credits with back-to-back sends
        for (int i = 1; i <= 10; i++)
            add(1, 8'(i), 0, 0, 1, 1, 8'(i), 4'(10 - i), 0);
        add(1, 8'h55, 0, 0, 0, 0, 8'h0A, 0, 0);
        // single credit return at zero credits
        add(1, 8'h66, 1, 0, BP, BP, BP ? 8'h66 : 8'h0A, BP ? 4'd0 : 4'd1, 0);
        add(1, 8'h77, 0, 0, ~BP, ~BP, BP ? 8'h66 : 8'h77, 0, 0);
        add(1, 8'h88, 0, 0, 0, 0, BP ? 8'h66 : 8'h77, 0, 0);
        // refill to five credits
        for (int i = 1; i <= 5; i++)
            add(0, 8'h00, 1, 0, (i == 1) ? BP : 1'b1, 0, BP ? 8'h66 : 8'h77, 4'(i), 0);
        // simultaneous send and return holds the count
        add(1, 8'h31, 1, 0, 1, 1, 8'h31, 5, 0);
        add(1, 8'h32, 0, 0, 1, 1, 8'h32, 4, 0);
        add(1, 8'h33, 0, 0, 1, 1, 8'h33, 3, 0);
        // clear mid-stream drops the send and the returned credit
        add(1, 8'h99, 1, 1, 0, 0, 8'h00, 10, 0);
        // overflow return sets the sticky error
        add(0, 8'h00, 1, 0, 1, 0, 8'h00, 10, 1);
        add(0, 8'h00, 0, 0, 1, 0, 8'h00, 10, 1);
        add(1, 8'h42, 0, 0, 1, 1, 8'h42, 9, 1);
        add(0, 8'h00, 0, 0, 1, 0, 8'h42, 9, 1);
        add(0, 8'h00, 0, 1, 0, 0, 8'h00, 10, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].valid, vecs[i].data, vecs[i].ret, vecs[i].clr);
            #1;
            chk($sformatf("v%0d_ready", i), 32'(bus.input_port_ready), 32'(vecs[i].e_ready));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_ov", i),  32'(bus.output_valid), 32'(vecs[i].e_ov));
            chk($sformatf("v%0d_od", i),  32'(bus.output_data),  32'(vecs[i].e_od));
            chk($sformatf("v%0d_cnt", i), 32'(bus.credit_count), 32'(vecs[i].e_cnt));
            chk($sformatf("v%0d_err", i), 32'(bus.credit_error), 32'(vecs[i].e_err));
        end

        // reset while a transfer is being accepted drops it
        drive(1, 8'hEE, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        drive(0, 8'h00, 0, 0);
        chk("rst_inflight_ov",  32'(bus.output_valid), 32'd0);
        chk("rst_inflight_od",  32'(bus.output_data),  32'd0);
        chk("rst_inflight_cnt", 32'(bus.credit_count), 32'd10);

        // ordered stream 0x01..0x0A with random valid gaps and receiver pops
        occ = 0; sent = 0; got = 0; next_data = 8'h01;
        for (int cyc = 0; cyc < 2000 && got < 10; cyc++) begin
            v_r = (sent < 10) && ($urandom_range(0, 2) != 0);
            r_r = (occ > 0) && ($urandom_range(0, 2) == 0);
            drive(v_r, next_data, r_r, 0);
            #1;
            model_cnt = 10 - occ;
            chk("strm_ready", 32'(bus.input_port_ready), 32'((model_cnt != 0) || (BP && r_r)));
            snd = v_r && ((model_cnt != 0) || (BP && r_r));
            @(posedge clk);
            #1;
            if (snd) begin
                exp_q.push_back(next_data);
                next_data++;
                sent++;
                occ++;
            end
            if (r_r) occ--;
            chk("strm_cnt", 32'(bus.credit_count), 32'(10 - occ));
            if (bus.credit_count > 4'd10) chk("strm_cnt_max", 32'(bus.credit_count), 32'd10);
            if (bus.output_valid) begin
                if (exp_q.size() == 0) begin
                    chk("strm_extra_pulse", 32'(bus.output_data), 32'hFFFF_FFFF);
                end else begin
                    chk("strm_data", 32'(bus.output_data), 32'(exp_q.pop_front()));
                    got++;
                end
            end
        end
        drive(0, 8'h00, 0, 0);
        chk("strm_received", 32'(got), 32'd10);
        chk("strm_err", 32'(bus.credit_error), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
